barrett_reduce_pipe: RTL and testbench

BARRETT_REDUCE_PIPE -- requirements
Module: barrett_reduce_pipe

---
 rtl/barrett_pkg.sv | 13 +
 rtl/barrett_cond_sub.sv | 15 +
 rtl/barrett_reduce_pipe.sv | 117 +++++++++++
 tb/tb_barrett_reduce_pipe.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_pkg.sv
// rtl/barrett_pkg.sv - shared widths, stage count and config record for the Barrett reducer
package barrett_pkg;
    localparam int DEF_DATA_WIDTH = 48;
    localparam int DEF_Q_WIDTH    = 23;
    localparam int DEF_K_WIDTH    = 6;
    localparam int NUM_STAGES     = 4;

    typedef struct packed {
        logic [DEF_Q_WIDTH-1:0] q;
        logic [DEF_Q_WIDTH+1:0] mu;
        logic [DEF_K_WIDTH-1:0] k;
    } barrett_cfg_t;
endpackage

// File: rtl/barrett_cond_sub.sv
// rtl/barrett_cond_sub.sv - two conditional subtractions of q, folding r < 3q into r < q
module barrett_cond_sub #(
    parameter int W = 23
) (
    input  logic [W+1:0] r_i,
    input  logic [W-1:0] q_i,
    output logic [W-1:0] res_o
);
    logic [W+1:0] q_ext;
    logic [W+1:0] r1;

    assign q_ext = {2'b00, q_i};
    assign r1    = (r_i >= q_ext) ? (r_i - q_ext) : r_i;
    assign res_o = (r1 >= q_ext) ? W'(r1 - q_ext) : W'(r1);
endmodule

// File: rtl/barrett_reduce_pipe.sv
// rtl/barrett_reduce_pipe.sv - 4-stage elastic Barrett reduction x mod Q
module barrett_reduce_pipe
    import barrett_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int Q_WIDTH    = DEF_Q_WIDTH,
    parameter int K_WIDTH    = DEF_K_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [Q_WIDTH-1:0]    cfg_q,
    input  logic [Q_WIDTH+1:0]    cfg_mu,
    input  logic [K_WIDTH-1:0]    cfg_k,
    output logic                  cfg_err,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_WIDTH-1:0]    out_data,
    output logic                  busy
);
    localparam int RW = Q_WIDTH + 2;
    localparam int PW = 2 * RW;

    logic [Q_WIDTH-1:0]    q_q;
    logic [RW-1:0]         mu_q;
    logic [K_WIDTH-1:0]    k_q;
    logic                  cfg_err_q, cfg_err_d;
    logic [NUM_STAGES-1:0] valid_q;
    logic [NUM_STAGES-1:0] stage_ready;

    logic [PW-1:0]         s1_prod_q, s1_prod_d;
    logic [RW-1:0]         s1_x_q;
    logic [RW-1:0]         s2_p_q, s2_p_d;
    logic [RW-1:0]         s2_x_q;
    logic [RW-1:0]         s3_r_q, s3_r_d;
    logic [Q_WIDTH-1:0]    s4_res_q, s4_res_d;

    logic [K_WIDTH-1:0]    k_m1;
    logic [K_WIDTH:0]      k_p1;
    logic [RW-1:0]         q1, q3;
    logic                  in_fire, cfg_accept;

    // A stage may load when empty or when its successor drains this cycle.
    assign stage_ready[3] = !valid_q[3] || out_ready;
    assign stage_ready[2] = !valid_q[2] || stage_ready[3];
    assign stage_ready[1] = !valid_q[1] || stage_ready[2];
    assign stage_ready[0] = !valid_q[0] || stage_ready[1];

    assign in_ready   = stage_ready[0] && (q_q != '0);
    assign in_fire    = in_valid && in_ready;
    assign busy       = |valid_q;
    assign cfg_accept = cfg_we && !busy && !in_valid;
    assign cfg_err_d  = cfg_we && !cfg_accept;

    // For x < Q^2 the shifted operand and quotient estimate fit in RW bits.
    assign k_m1      = k_q - K_WIDTH'(1);
    assign k_p1      = (K_WIDTH+1)'(k_q) + (K_WIDTH+1)'(1);
    assign q1        = RW'(in_data >> k_m1);
    assign s1_prod_d = PW'(q1) * PW'(mu_q);
    assign q3        = RW'(s1_prod_q >> k_p1);
    assign s2_p_d    = q3 * RW'(q_q);
    assign s3_r_d    = s2_x_q - s2_p_q;

    barrett_cond_sub #(.W(Q_WIDTH)) u_cond_sub (
        .r_i   (s3_r_q),
        .q_i   (q_q),
        .res_o (s4_res_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q       <= '0;
            mu_q      <= '0;
            k_q       <= '0;
            cfg_err_q <= 1'b0;
            valid_q   <= '0;
            s1_prod_q <= '0;
            s1_x_q    <= '0;
            s2_p_q    <= '0;
            s2_x_q    <= '0;
            s3_r_q    <= '0;
            s4_res_q  <= '0;
        end else begin
            cfg_err_q <= cfg_err_d;
            if (cfg_accept) begin
                q_q  <= cfg_q;
                mu_q <= cfg_mu;
                k_q  <= cfg_k;
            end
            if (stage_ready[0]) begin
                valid_q[0] <= in_fire;
                s1_prod_q  <= s1_prod_d;
                s1_x_q     <= RW'(in_data);
            end
            if (stage_ready[1]) begin
                valid_q[1] <= valid_q[0];
                s2_p_q     <= s2_p_d;
                s2_x_q     <= s1_x_q;
            end
            if (stage_ready[2]) begin
                valid_q[2] <= valid_q[1];
                s3_r_q     <= s3_r_d;
            end
            if (stage_ready[3]) begin
                valid_q[3] <= valid_q[2];
                s4_res_q   <= s4_res_d;
            end
        end
    end

    assign cfg_err   = cfg_err_q;
    assign out_valid = valid_q[3];
    assign out_data  = s4_res_q;
endmodule

// File: tb/tb_barrett_reduce_pipe.sv
// tb/tb_barrett_reduce_pipe.sv - self-checking bench for barrett_reduce_pipe
module tb_barrett_reduce_pipe;
    import barrett_pkg::*;

    localparam int DW      = 48;
    localparam int QW      = 23;
    localparam int KW      = 6;
    localparam int LATENCY = NUM_STAGES;

    typedef struct {
        longint unsigned q;
        longint unsigned mu;
        int              k;
        longint unsigned x;
        longint unsigned exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          cfg_we = 1'b0;
    logic [QW-1:0] cfg_q = '0;
    logic [QW+1:0] cfg_mu = '0;
    logic [KW-1:0] cfg_k = '0;
    logic          cfg_err;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [QW-1:0] out_data;
    logic          busy;

    barrett_reduce_pipe #(.DATA_WIDTH(DW), .Q_WIDTH(QW), .K_WIDTH(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_q     (cfg_q),
        .cfg_mu    (cfg_mu),
        .cfg_k     (cfg_k),
        .cfg_err   (cfg_err),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int              cyc = 0;
    int              checks = 0;
    int              failures = 0;
    barrett_cfg_t    cur_cfg = '0;
    longint unsigned exp_q[$];
    logic            mon_en = 1'b0;
    int              mon_cnt = 0;
    int              mon_first = -1;
    int              mon_last = -1;
    longint unsigned mon_exp;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint unsigned act,
                                  input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endfunction

    function automatic longint unsigned ref_mod(input longint unsigned x);
        return x % longint'(cur_cfg.q);
    endfunction

    function automatic longint unsigned rnd_x(input longint unsigned q);
        longint unsigned r;
        r = {$urandom(), $urandom()};
        return r % (q * q);
    endfunction

    // Scoreboard: every accepted result must match the head of the x mod Q queue.
    always @(negedge clk) begin
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0d, required no result", out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", out_data, mon_exp);
                mon_cnt++;
                if (mon_first < 0) mon_first = cyc;
                mon_last = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input longint unsigned q, input longint unsigned mu, input int k);
        cfg_we = 1'b1;
        cfg_q  = QW'(q);
        cfg_mu = (QW+2)'(mu);
        cfg_k  = KW'(k);
        step();
        cfg_we = 1'b0;
        cur_cfg.q  = QW'(q);
        cur_cfg.mu = (QW+2)'(mu);
        cur_cfg.k  = KW'(k);
        @(negedge clk);
        check("cfg_err_on_accept", cfg_err, 0);
        step();
    endtask

    task automatic send(input longint unsigned x, output int t);
        in_valid = 1'b1;
        in_data  = DW'(x);
        t = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                step();
                t = cyc;
                exp_q.push_back(ref_mod(x));
                break;
            end
        end
        if (t < 0) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: in_ready=%0d, required 1", in_ready);
            step();
        end
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 80 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached after %0d checks", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t            vecs[6];
        int              t, t0, tl, seen, base, acc, sent, stale, blk;
        logic            fire, rdy, took;
        longint unsigned x, held, qq;

        vecs[0] = '{64'd8380417, 64'd8396807, 23, 64'd8380417 * 64'd8380416, 64'd0};
        vecs[1] = '{64'd8380417, 64'd8396807, 23, 64'd8380416, 64'd8380416};
        vecs[2] = '{64'd8380417, 64'd8396807, 23, 64'd8380416 * 64'd8380416, 64'd1};
        vecs[3] = '{64'd3329, 64'd5039, 12, 64'd3328 * 64'd3328, 64'd1};
        vecs[4] = '{64'd3329, 64'd5039, 12, 64'd3329, 64'd0};
        vecs[5] = '{64'd3329, 64'd5039, 12, 64'd6657, 64'd3328};

        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_out_data", out_data, 0);
        rst_n = 1'b1;
        step();

        // Unconfigured (Q == 0) must refuse operands.
        in_valid = 1'b1;
        in_data  = DW'(5);
        repeat (3) begin
            @(negedge clk);
            check("in_ready_unconfigured", in_ready, 0);
        end
        step();
        check("busy_unconfigured", busy, 0);
        in_valid = 1'b0;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].q != longint'(cur_cfg.q)) do_cfg(vecs[i].q, vecs[i].mu, vecs[i].k);
            send(vecs[i].x, t);
            in_valid = 1'b0;
            seen = -1;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                if (out_valid) begin
                    seen = cyc;
                    break;
                end
            end
            check($sformatf("vec%0d_data", i), out_data, vecs[i].exp);
            check($sformatf("vec%0d_latency", i), longint'(seen - t + 1), LATENCY);
            exp_q.delete();
            step();
        end

        // 100 back-to-back random operands, Q = 8380417.
        do_cfg(64'd8380417, 64'd8396807, 23);
        mon_en = 1'b1;
        mon_cnt = 0;
        mon_first = -1;
        t0 = 0;
        tl = 0;
        for (int i = 0; i < 100; i++) begin
            send(rnd_x(64'd8380417), t);
            if (i == 0) t0 = t;
            tl = t;
        end
        in_valid = 1'b0;
        wait_drain("b2b_drain");
        check("b2b_accept_span", longint'(tl - t0), 99);
        check("b2b_count", mon_cnt, 100);
        check("b2b_output_span", longint'(mon_last - mon_first), 99);

        // Random valid gaps and backpressure, Q = 3329 with mu derived here.
        qq = 64'd3329;
        do_cfg(qq, (64'd1 << 24) / qq, 12);
        base = mon_cnt;
        sent = 0;
        took = 1'b1;
        x = 0;
        for (int c = 0; c < 300; c++) begin
            if (took || !in_valid) begin
                x        = rnd_x(qq);
                in_data  = DW'(x);
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            fire = in_valid && in_ready;
            step();
            took = fire;
            if (fire) begin
                exp_q.push_back(ref_mod(x));
                sent++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain("bp_drain");
        check("bp_count", longint'(mon_cnt - base), longint'(sent));

        // Full pipe with out_ready low: exactly 4 accepted, output frozen.
        base = mon_cnt;
        out_ready = 1'b0;
        acc = 0;
        x = rnd_x(qq);
        in_data = DW'(x);
        in_valid = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            rdy = in_ready;
            step();
            if (rdy) begin
                exp_q.push_back(ref_mod(x));
                acc++;
                x = rnd_x(qq);
                in_data = DW'(x);
            end
        end
        check("stall_accepted", acc, 4);
        @(negedge clk);
        check("stall_in_ready", in_ready, 0);
        check("stall_out_valid", out_valid, 1);
        held = out_data;
        check("stall_head", held, exp_q[0]);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_out_data_stable", out_data, held);
            check("stall_out_valid_held", out_valid, 1);
        end
        step();
        out_ready = 1'b1;
        @(negedge clk);
        check("release_in_ready", in_ready, 1);
        step();
        exp_q.push_back(ref_mod(x));
        in_valid = 1'b0;
        wait_drain("stall_drain");
        check("stall_count", longint'(mon_cnt - base), 5);

        // Config write while busy must be rejected and leave Q = 3329 in force.
        base = mon_cnt;
        send(64'd6657, t);
        in_valid = 1'b0;
        check("busy_in_flight", busy, 1);
        cfg_we = 1'b1;
        cfg_q  = QW'(8380417);
        cfg_mu = (QW+2)'(8396807);
        cfg_k  = KW'(23);
        step();
        cfg_we = 1'b0;
        @(negedge clk);
        check("cfg_err_pulse", cfg_err, 1);
        @(negedge clk);
        check("cfg_err_one_cycle", cfg_err, 0);
        step();
        wait_drain("cfg_busy_drain");
        send(64'd3329 * 64'd100 + 64'd7, t);
        in_valid = 1'b0;
        wait_drain("cfg_old_q_drain");
        check("cfg_busy_count", longint'(mon_cnt - base), 2);

        // Reset with 3 operands in flight.
        mon_en = 1'b0;
        send(rnd_x(qq), t);
        send(rnd_x(qq), t);
        send(rnd_x(qq), t);
        in_valid = 1'b0;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out_data", out_data, 0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        stale = 0;
        blk = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
            if (in_ready) blk++;
        end
        check("postrst_stale_out", stale, 0);
        check("postrst_in_ready", blk, 0);
        step();
        do_cfg(64'd3329, 64'd5039, 12);
        stale = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("reconfig_stale_out", stale, 0);
        step();
        mon_en = 1'b1;
        base = mon_cnt;
        send(64'd3328 * 64'd3328, t);
        in_valid = 1'b0;
        wait_drain("postrst_drain");
        check("postrst_count", longint'(mon_cnt - base), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
